// File: rtl/conv2_pkg.sv
// Shared types and sizing for the conv2 3x3 window sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: FILTER_SIZE, default geometry, FSM state enum, width helper.
package conv2_pkg;

  localparam int FILTER_SIZE = 3;

  // Default conv2 input geometry.
  localparam int DEF_WIDTH     = 15;
  localparam int DEF_HEIGHT    = 19;
  localparam int DEF_CHANNELS  = 3;
  localparam int DEF_DATA_BITS = 32;

  // Line-buffer slot index width (one slot per filter row).
  localparam int SLOT_W = $clog2(FILTER_SIZE);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } conv2_ctrl_state_t;

  // $clog2 with a floor of one bit so single-valued counters still get a wire.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/conv2_pos_cnt.sv
// Column/row/line-buffer-slot/channel position counter for the conv2 pixel stream.
// Latency: position advances on the edge of each adv_i; terminal flags are combinational.
// Backpressure: none; advances only when the parent accepts a pixel.
// Ports: clk, rst_n, clr_i (restart at 0,0,slot 0,ch 0), adv_i (one pixel accepted),
//        col_o/row_o/slot_o/ch_o (position of the next pixel), *_last_o terminal flags.
module conv2_pos_cnt
  import conv2_pkg::*;
#(
  parameter  int WIDTH    = DEF_WIDTH,
  parameter  int HEIGHT   = DEF_HEIGHT,
  parameter  int CHANNELS = DEF_CHANNELS,
  localparam int COL_W    = clog2_min1(WIDTH),
  localparam int ROW_W    = clog2_min1(HEIGHT),
  localparam int CH_W     = clog2_min1(CHANNELS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic              adv_i,
  output logic [COL_W-1:0]  col_o,
  output logic [ROW_W-1:0]  row_o,
  output logic [SLOT_W-1:0] slot_o,
  output logic [CH_W-1:0]   ch_o,
  output logic              col_last_o,
  output logic              row_last_o,
  output logic              ch_last_o
);

  logic [COL_W-1:0]  col_q,  col_d;
  logic [ROW_W-1:0]  row_q,  row_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [CH_W-1:0]   ch_q,   ch_d;

  assign col_last_o = (col_q == COL_W'(WIDTH - 1));
  assign row_last_o = (row_q == ROW_W'(HEIGHT - 1));
  assign ch_last_o  = (ch_q  == CH_W'(CHANNELS - 1));

  always_comb begin
    col_d  = col_q;
    row_d  = row_q;
    slot_d = slot_q;
    ch_d   = ch_q;
    if (clr_i) begin
      col_d  = '0;
      row_d  = '0;
      slot_d = '0;
      ch_d   = '0;
    end else if (adv_i) begin
      if (col_last_o) begin
        col_d = '0;
        if (row_last_o) begin
          // Every channel restarts the line buffer at slot 0; HEIGHT need not be
          // a multiple of FILTER_SIZE. The channel wraps after the last one so
          // the counters are back at zero once the frame is complete.
          row_d  = '0;
          slot_d = '0;
          ch_d   = ch_last_o ? '0 : ch_q + 1'b1;
        end else begin
          row_d  = row_q + 1'b1;
          slot_d = (slot_q == SLOT_W'(FILTER_SIZE - 1)) ? '0 : slot_q + 1'b1;
        end
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q  <= '0;
      row_q  <= '0;
      slot_q <= '0;
      ch_q   <= '0;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      slot_q <= slot_d;
      ch_q   <= ch_d;
    end
  end

  assign col_o  = col_q;
  assign row_o  = row_q;
  assign slot_o = slot_q;
  assign ch_o   = ch_q;

endmodule

// File: rtl/conv2_stream_ctrl.sv
// Sequencer for the conv2 3x3 line-buffer window stage: writes pixels into the rotating buffer, issues windows.
// Latency: 1 cycle from pixel accept to buffer write and to the window request it completes.
// Backpressure: in_ready drops while a window request is pending and win_ready is low.
// Ports: start/in_valid/in_data/in_ready pixel side; buf_wr_* line-buffer write; win_* window
//        request with win_ready handshake; ch_idx channel of current write/window; busy; done pulse.
module conv2_stream_ctrl
  import conv2_pkg::*;
#(
  parameter  int WIDTH     = DEF_WIDTH,
  parameter  int HEIGHT    = DEF_HEIGHT,
  parameter  int CHANNELS  = DEF_CHANNELS,
  parameter  int DATA_BITS = DEF_DATA_BITS,
  localparam int ADDR_W    = clog2_min1(WIDTH * FILTER_SIZE),
  localparam int COL_W     = clog2_min1(WIDTH),
  localparam int ROW_W     = clog2_min1(HEIGHT),
  localparam int CH_W      = clog2_min1(CHANNELS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 in_valid,
  input  logic [DATA_BITS-1:0] in_data,
  output logic                 in_ready,
  output logic                 buf_wr_en,
  output logic [ADDR_W-1:0]    buf_wr_addr,
  output logic [DATA_BITS-1:0] buf_wr_data,
  output logic                 win_valid,
  input  logic                 win_ready,
  output logic [ROW_W-1:0]     win_row,
  output logic [COL_W-1:0]     win_col,
  output logic [SLOT_W-1:0]    win_base,
  output logic [CH_W-1:0]      ch_idx,
  output logic                 busy,
  output logic                 done
);

  conv2_ctrl_state_t state_q, state_d;

  logic                 accept;
  logic                 clr;
  logic                 done_q, done_d;

  logic [COL_W-1:0]     pos_col;
  logic [ROW_W-1:0]     pos_row;
  logic [SLOT_W-1:0]    pos_slot;
  logic [CH_W-1:0]      pos_ch;
  logic                 col_last, row_last, ch_last;
  logic                 win_ok;

  logic                 wr_en_q,   wr_en_d;
  logic [ADDR_W-1:0]    wr_addr_q, wr_addr_d;
  logic [DATA_BITS-1:0] wr_data_q, wr_data_d;
  logic                 win_vld_q, win_vld_d;
  logic [ROW_W-1:0]     win_row_q, win_row_d;
  logic [COL_W-1:0]     win_col_q, win_col_d;
  logic [SLOT_W-1:0]    win_base_q, win_base_d;
  logic [CH_W-1:0]      ch_idx_q,  ch_idx_d;

  // A pending window that downstream will not take this cycle freezes the stream,
  // so the window coordinates and channel stay valid until the handshake.
  assign in_ready = (state_q == RUN) && !(win_vld_q && !win_ready);
  assign accept   = in_valid && in_ready;

  conv2_pos_cnt #(
    .WIDTH    (WIDTH),
    .HEIGHT   (HEIGHT),
    .CHANNELS (CHANNELS)
  ) u_pos_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (clr),
    .adv_i      (accept),
    .col_o      (pos_col),
    .row_o      (pos_row),
    .slot_o     (pos_slot),
    .ch_o       (pos_ch),
    .col_last_o (col_last),
    .row_last_o (row_last),
    .ch_last_o  (ch_last)
  );

  always_comb begin
    state_d = state_q;
    clr     = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          clr     = 1'b1;
        end
      end
      RUN: begin
        if (accept && col_last && row_last && ch_last) state_d = DRAIN;
      end
      DRAIN: begin
        // The last pixel always completes a window; finish once it is taken.
        if (win_vld_q && win_ready) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Pixel (r,c) with r,c >= 2 is the bottom-right corner of window (r-2,c-2).
  assign win_ok = (pos_row >= ROW_W'(2)) && (pos_col >= COL_W'(2));

  always_comb begin
    wr_en_d    = accept;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    ch_idx_d   = ch_idx_q;
    win_vld_d  = win_vld_q && !win_ready;
    win_row_d  = win_row_q;
    win_col_d  = win_col_q;
    win_base_d = win_base_q;
    if (clr) ch_idx_d = '0;
    if (accept) begin
      wr_addr_d = ADDR_W'(pos_slot) * ADDR_W'(WIDTH) + ADDR_W'(pos_col);
      wr_data_d = in_data;
      ch_idx_d  = pos_ch;
      if (win_ok) begin
        win_vld_d = 1'b1;
        win_row_d = pos_row - ROW_W'(2);
        win_col_d = pos_col - COL_W'(2);
        // Row r sits in slot r mod 3, so the top row r-2 sits one slot further on.
        win_base_d = (pos_slot == SLOT_W'(FILTER_SIZE - 1)) ? '0 : pos_slot + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      done_q     <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      ch_idx_q   <= '0;
      win_vld_q  <= 1'b0;
      win_row_q  <= '0;
      win_col_q  <= '0;
      win_base_q <= '0;
    end else begin
      state_q    <= state_d;
      done_q     <= done_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      ch_idx_q   <= ch_idx_d;
      win_vld_q  <= win_vld_d;
      win_row_q  <= win_row_d;
      win_col_q  <= win_col_d;
      win_base_q <= win_base_d;
    end
  end

  assign buf_wr_en   = wr_en_q;
  assign buf_wr_addr = wr_addr_q;
  assign buf_wr_data = wr_data_q;
  assign win_valid   = win_vld_q;
  assign win_row     = win_row_q;
  assign win_col     = win_col_q;
  assign win_base    = win_base_q;
  assign ch_idx      = ch_idx_q;
  assign busy        = (state_q != IDLE);
  assign done        = done_q;

endmodule
